// File: rtl/render_pkg.sv
// Shared types and register map for the render command master.
package render_pkg;

    localparam logic [3:0] ADDR_X    = 4'd1;
    localparam logic [3:0] ADDR_Y    = 4'd2;
    localparam logic [3:0] ADDR_NEG  = 4'd3;
    localparam logic [3:0] ADDR_TEX  = 4'd4;
    localparam logic [3:0] ADDR_PLOT = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TEX,
        ST_NEG_SET,
        ST_X,
        ST_Y,
        ST_NEG_CLR,
        ST_PLOT
    } state_t;

    typedef struct packed {
        logic [7:0] tex;
        logic [8:0] x;
        logic [7:0] y;
        logic       neg;
    } cmd_t;

endpackage

// File: rtl/render_cmd_fifo.sv
// Synchronous command FIFO of cmd_t entries with full/empty flags.
module render_cmd_fifo
    import render_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t           r_mem [DEPTH];
    logic [AW-1:0]  r_wrPtr;
    logic [AW-1:0]  r_rdPtr;
    logic [AW:0]    r_count;
    logic           w_doPush;
    logic           w_doPop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    // A push into a full FIFO is only legal when a pop frees the slot.
    assign w_doPush = i_push && (!o_full || i_pop);
    assign w_doPop  = i_pop && !o_empty;
    assign o_data   = r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/render_cmd_master.sv
// Avalon-MM initiator expanding queued draw commands into render register writes.
// Define RENDER_CMD_SKIP_EN to suppress writes that repeat the last accepted tex/x/y.
module render_cmd_master
    import render_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_tex,
    input  logic [8:0]       cmd_x,
    input  logic [7:0]       cmd_y,
    input  logic             cmd_neg,
    output logic [3:0]       master_address,
    output logic             master_write,
    output logic [31:0]      master_writedata,
    output logic             master_read,
    input  logic             master_waitrequest,
    output logic             busy,
    output logic [CNT_W-1:0] plots_done
);

    state_t           r_state;
    state_t           w_nextState;
    state_t           w_afterTex;
    cmd_t             r_cmd;
    cmd_t             w_fifoIn;
    cmd_t             w_fifoOut;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_accept;
    logic             w_skipTex;
    logic             w_skipX;
    logic             w_skipY;
    logic [CNT_W-1:0] r_plots;

    assign w_fifoIn    = '{tex: cmd_tex, x: cmd_x, y: cmd_y, neg: cmd_neg};
    assign cmd_ready   = !w_full;
    assign busy        = (r_state != ST_IDLE) || !w_empty;
    assign master_read = 1'b0;
    assign plots_done  = r_plots;
    assign w_accept    = master_write && !master_waitrequest;
    assign w_afterTex  = r_cmd.tex[7] ? ST_PLOT : (r_cmd.neg ? ST_NEG_SET : ST_X);

    render_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (cmd_valid && cmd_ready),
        .i_data  (w_fifoIn),
        .i_pop   (w_pop),
        .o_data  (w_fifoOut),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef RENDER_CMD_SKIP_EN
    logic [7:0] r_shTex;
    logic [8:0] r_shX;
    logic [7:0] r_shY;
    logic       r_shTexV;
    logic       r_shXV;
    logic       r_shYV;

    // Negative commands always rewrite X/Y, so they poison the shadows.
    assign w_skipTex = r_shTexV && (r_shTex == r_cmd.tex);
    assign w_skipX   = !r_cmd.neg && r_shXV && (r_shX == r_cmd.x);
    assign w_skipY   = !r_cmd.neg && r_shYV && (r_shY == r_cmd.y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shTex  <= '0;
            r_shX    <= '0;
            r_shY    <= '0;
            r_shTexV <= 1'b0;
            r_shXV   <= 1'b0;
            r_shYV   <= 1'b0;
        end else if (w_accept) begin
            if (r_state == ST_TEX) begin
                r_shTex  <= r_cmd.tex;
                r_shTexV <= 1'b1;
            end
            if (r_state == ST_X) begin
                r_shX  <= r_cmd.x;
                r_shXV <= !r_cmd.neg;
            end
            if (r_state == ST_Y) begin
                r_shY  <= r_cmd.y;
                r_shYV <= !r_cmd.neg;
            end
        end
    end
`else
    assign w_skipTex = 1'b0;
    assign w_skipX   = 1'b0;
    assign w_skipY   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_plots <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_pop) r_cmd <= w_fifoOut;
            if (r_state == ST_PLOT && w_accept) r_plots <= r_plots + CNT_W'(1);
        end
    end

    // Outputs are decoded from state and the held command, so they stay
    // stable for as long as waitrequest stalls a beat.
    always_comb begin
        w_nextState      = r_state;
        w_pop            = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_nextState = ST_TEX;
                end
            end
            ST_TEX: begin
                master_address   = ADDR_TEX;
                master_writedata = {24'd0, r_cmd.tex};
                master_write     = !w_skipTex;
                if (w_skipTex || w_accept) w_nextState = w_afterTex;
            end
            ST_NEG_SET: begin
                master_address   = ADDR_NEG;
                master_writedata = 32'd1;
                master_write     = 1'b1;
                if (w_accept) w_nextState = ST_X;
            end
            ST_X: begin
                master_address   = ADDR_X;
                master_writedata = {23'd0, r_cmd.x};
                master_write     = !w_skipX;
                if (w_skipX || w_accept) w_nextState = ST_Y;
            end
            ST_Y: begin
                master_address   = ADDR_Y;
                master_writedata = {24'd0, r_cmd.y};
                master_write     = !w_skipY;
                if (w_skipY || w_accept) w_nextState = r_cmd.neg ? ST_NEG_CLR : ST_PLOT;
            end
            ST_NEG_CLR: begin
                master_address   = ADDR_NEG;
                master_writedata = 32'd0;
                master_write     = 1'b1;
                if (w_accept) w_nextState = ST_PLOT;
            end
            ST_PLOT: begin
                master_address   = ADDR_PLOT;
                master_writedata = 32'd0;
                master_write     = 1'b1;
                if (w_accept) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_nextState = ST_TEX;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_render_cmd_master.sv
// Scoreboard bench for render_cmd_master: a command-level model queues expected
// register writes, and a monitor compares every accepted Avalon beat against them.
module tb_render_cmd_master;
    import render_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
`ifdef RENDER_CMD_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_tex;
    logic [8:0]       cmd_x;
    logic [7:0]       cmd_y;
    logic             cmd_neg;
    logic [3:0]       master_address;
    logic             master_write;
    logic [31:0]      master_writedata;
    logic             master_read;
    logic             master_waitrequest;
    logic             busy;
    logic [CNT_W-1:0] plots_done;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } beat_t;

    beat_t      expQ[$];
    int         checks = 0;
    int         errors = 0;
    int         modelPlots = 0;
    logic [7:0] shTex;
    logic [8:0] shX;
    logic [7:0] shY;
    bit         shTexV = 0;
    bit         shXV = 0;
    bit         shYV = 0;
    int         waitMode = 0;
    int         stallLeft = 0;
    logic [3:0] stallAddr = ADDR_PLOT;
    bit         plotPending = 0;

    render_cmd_master #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_tex            (cmd_tex),
        .cmd_x              (cmd_x),
        .cmd_y              (cmd_y),
        .cmd_neg            (cmd_neg),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_read        (master_read),
        .master_waitrequest (master_waitrequest),
        .busy               (busy),
        .plots_done         (plots_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic expectBeat(input logic [3:0] addr, input logic [31:0] data);
        beat_t b;
        b.addr = addr;
        b.data = data;
        expQ.push_back(b);
    endtask

    // Command-level reference: which register writes a command produces.
    task automatic modelCommand(input logic [7:0] tex, input logic [8:0] x, input logic [7:0] y, input logic neg);
        if (!(SKIP_EN && shTexV && shTex == tex)) expectBeat(ADDR_TEX, 32'(tex));
        shTex  = tex;
        shTexV = 1;
        if (!tex[7]) begin
            if (neg) begin
                expectBeat(ADDR_NEG, 32'd1);
                expectBeat(ADDR_X, 32'(x));
                expectBeat(ADDR_Y, 32'(y));
                expectBeat(ADDR_NEG, 32'd0);
                shXV = 0;
                shYV = 0;
            end else begin
                if (!(SKIP_EN && shXV && shX == x)) expectBeat(ADDR_X, 32'(x));
                if (!(SKIP_EN && shYV && shY == y)) expectBeat(ADDR_Y, 32'(y));
                shX  = x;
                shY  = y;
                shXV = 1;
                shYV = 1;
            end
        end
        expectBeat(ADDR_PLOT, 32'd0);
    endtask

    task automatic resetModel();
        expQ.delete();
        modelPlots = 0;
        shTexV = 0;
        shXV = 0;
        shYV = 0;
    endtask

    // Enter at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic applyStimulus(input logic [7:0] tex, input logic [8:0] x, input logic [7:0] y, input logic neg);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_tex = tex;
        cmd_x = x;
        cmd_y = y;
        cmd_neg = neg;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 500);
        if (!cmd_ready) begin
            checkOutput("push_timeout", 64'(cmd_ready), 64'd1);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        modelCommand(tex, x, y, neg);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_drained"}, 64'(expQ.size()), 64'd0);
        checkOutput({name, "_idle_busy"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        master_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (waitMode)
                0: master_waitrequest = 1'b0;
                1: master_waitrequest = 1'b1;
                2: master_waitrequest = ($urandom_range(0, 3) == 0);
                default: begin
                    if (master_write && master_address == stallAddr && stallLeft > 0) begin
                        master_waitrequest = 1'b1;
                        stallLeft--;
                    end else begin
                        master_waitrequest = 1'b0;
                    end
                end
            endcase
        end
    end

    // Monitor: checks accepted beats, stall stability and plots_done.
    initial begin
        logic        prevStall;
        logic [36:0] prevBus;
        beat_t       b;
        prevStall = 1'b0;
        prevBus = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevStall = 1'b0;
                plotPending = 0;
            end else begin
                if (plotPending) begin
                    checkOutput("plots_done", 64'(plots_done), 64'(modelPlots % (1 << CNT_W)));
                    plotPending = 0;
                end
                if (prevStall) begin
                    checkOutput("stall_hold", 64'({master_write, master_address, master_writedata}), 64'(prevBus));
                end
                if (master_write && !master_waitrequest) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_beat_addr", 64'(master_address), 64'hF);
                    end else begin
                        b = expQ.pop_front();
                        checkOutput("beat_addr", 64'(master_address), 64'(b.addr));
                        checkOutput("beat_data", 64'(master_writedata), 64'(b.data));
                        if (b.addr == ADDR_PLOT) begin
                            modelPlots++;
                            plotPending = 1;
                        end
                    end
                end
                prevStall = master_write && master_waitrequest;
                prevBus = {master_write, master_address, master_writedata};
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] rTex;
        cmd_valid = 1'b0;
        cmd_tex = '0;
        cmd_x = '0;
        cmd_y = '0;
        cmd_neg = 1'b0;
        rst_n = 1'b0;
        #12;
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("rst_write", 64'(master_write), 64'd0);
        checkOutput("rst_address", 64'(master_address), 64'd0);
        checkOutput("rst_writedata", 64'(master_writedata), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_plots", 64'(plots_done), 64'd0);
        checkOutput("read_tied", 64'(master_read), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] sprite latency and back-to-back beats");
        applyStimulus(8'h01, 9'd20, 8'd20, 1'b0);
        @(negedge clk);
        checkOutput("lat_first_cycle_write", 64'(master_write), 64'd0);
        checkOutput("lat_first_cycle_busy", 64'(busy), 64'd1);
        @(negedge clk);
        checkOutput("lat_tex_addr", 64'(master_address), 64'(ADDR_TEX));
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("sprite_back_to_back", 64'(master_write), 64'd1);
        end
        @(negedge clk);
        checkOutput("sprite_busy_after_plot", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] fill command");
        applyStimulus(8'hFC, 9'd0, 8'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("fill_tex_write", 64'(master_write), 64'd1);
        @(negedge clk);
        checkOutput("fill_plot_addr", 64'(master_address), 64'(ADDR_PLOT));
        @(negedge clk);
        checkOutput("fill_busy_after_plot", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] negative sprite");
        applyStimulus(8'h06, 9'd1, 8'd1, 1'b1);
        waitDrain("negative");

        $display("[TB] long PLOT stall with a queued command");
        waitMode = 3;
        stallAddr = ADDR_PLOT;
        stallLeft = 50;
        applyStimulus(8'h02, 9'd30, 8'd40, 1'b0);
        applyStimulus(8'h03, 9'd31, 8'd41, 1'b0);
        waitDrain("stall");
        waitMode = 0;

        $display("[TB] FIFO full");
        waitMode = 1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(8'(8'h10 + i), 9'(100 + i), 8'(50 + i), 1'(i % 2));
        end
        cmd_valid = 1'b1;
        cmd_tex = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("full_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        waitMode = 0;
        waitDrain("full");

        $display("[TB] repeated sprite");
        applyStimulus(8'h01, 9'd20, 8'd20, 1'b0);
        applyStimulus(8'h01, 9'd20, 8'd20, 1'b0);
        waitDrain("repeat");

        $display("[TB] randomized commands");
        waitMode = 2;
        for (int i = 0; i < 80; i++) begin
            rTex = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            applyStimulus(rTex, 9'($urandom_range(0, 3) == 0 ? 5 : $urandom_range(0, 511)),
                          8'($urandom_range(0, 3) == 0 ? 7 : $urandom_range(0, 255)),
                          1'($urandom_range(0, 3) == 0));
            n = $urandom_range(0, 3);
            repeat (n) @(posedge clk);
            #1;
        end
        waitDrain("random");
        waitMode = 0;
        checkOutput("final_plots", 64'(plots_done), 64'(modelPlots % (1 << CNT_W)));

        $display("[TB] reset mid-sequence");
        waitMode = 3;
        stallAddr = ADDR_X;
        stallLeft = 1000;
        applyStimulus(8'h05, 9'd9, 8'd9, 1'b1);
        applyStimulus(8'h07, 9'd2, 8'd3, 1'b0);
        applyStimulus(8'h08, 9'd4, 8'd5, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(master_write && master_address == ADDR_X) && n < 100);
        checkOutput("reset_reached_x", 64'(master_address), 64'(ADDR_X));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_write", 64'(master_write), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("midrst_plots", 64'(plots_done), 64'd0);
        resetModel();
        stallLeft = 0;
        waitMode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("postrst_busy", 64'(busy), 64'd0);
        checkOutput("postrst_write", 64'(master_write), 64'd0);

        $display("[TB] repeated sprite after reset");
        @(posedge clk);
        #1;
        applyStimulus(8'h01, 9'd20, 8'd20, 1'b0);
        applyStimulus(8'h01, 9'd20, 8'd20, 1'b0);
        waitDrain("post_reset_repeat");
        checkOutput("post_reset_plots", 64'(plots_done), 64'd2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/render_cmd_master.md
Name: render_cmd_master

Overview:
- Avalon-MM initiator that drives the render block's slave port (clk domain shared with render).
- Accepts draw commands (texture code, midpoint x/y, negative flag) on a valid/ready stream and buffers them in a small FIFO.
- Expands each command into the render register-write sequence, honouring waitrequest.
- Lets the HPS/software or a game-logic FSM queue whole frames without polling render.

Parameters:
- DEPTH, 8, command FIFO entries (power of two, ≥2)
- CNT_W, 16, width of plots_done counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_tex  in  8  texture/colour code; bit7=1 means full-screen fill/line (no coordinates)
- cmd_x  in  9  midpoint x magnitude (0..319)
- cmd_y  in  8  midpoint y magnitude (0..239)
- cmd_neg  in  1  coordinates are negative (-cmd_x, -cmd_y)
- master_address  out  4  render register index
- master_write  out  1  write strobe
- master_writedata  out  32  write data, zero-extended
- master_read  out  1  tied 0
- master_waitrequest  in  1  render stall
- busy  out  1  FIFO non-empty or sequence in progress
- plots_done  out  CNT_W  count of accepted PLOT writes, wraps

Behaviour:
- Reset values: cmd_ready=1, master_write=0, master_address=0, master_writedata=0, busy=0, plots_done=0, FIFO empty, FSM=IDLE.
- Push when cmd_valid && cmd_ready. cmd_ready=0 when DEPTH entries are held. A push into a full FIFO is impossible by handshake. A simultaneous push and pop on a full FIFO is allowed and keeps the count.
- Beat accepted on a cycle with master_write=1 && master_waitrequest=0. While waitrequest=1, address, data and write are held stable.
- FSM states:
  - IDLE: if FIFO non-empty, pop into the command register and go to TEX. Otherwise stay.
  - TEX: write addr 4 = cmd_tex. Next: if tex[7], PLOT; else if neg, NEG_SET; else X.
  - NEG_SET: write addr 3 = 1 → X.
  - X: write addr 1 = cmd_x → Y.
  - Y: write addr 2 = cmd_y. Next: if neg, NEG_CLR; else PLOT.
  - NEG_CLR: write addr 3 = 0 → PLOT.
  - PLOT: write addr 6 = 0. On accept, plots_done += 1.
- After a PLOT accept: if the FIFO is non-empty, pop and go to TEX in the same cycle; else go to IDLE.
- Beats are back-to-back: after an accept, the next beat is presented the following cycle, with master_write staying high.
- Render holds waitrequest while plotting, so the next command's TEX beat stalls naturally.
- Latency: earliest TEX beat is 2 cycles after the command handshake (FIFO write, then IDLE pop). A non-negative sprite with no stalls takes 4 beats; a negative one takes 6; a fill takes 2.
- busy = (FSM≠IDLE) || FIFO non-empty.
- Reset mid-operation: everything clears immediately, including an in-flight write and queued commands. Software re-issues the frame.
- Out-of-range x/y are passed unchanged; clipping is render's responsibility.

Optional Feature:
- Macro: RENDER_CMD_SKIP_EN.
- When defined:
  - Shadow registers (tex, x, y, each with a valid bit) record the last accepted values.
  - A TEX beat is skipped if tex equals shadow_tex and it is valid.
  - X/Y beats of non-negative commands are skipped if they equal valid shadows.
  - Negative commands always write X/Y and invalidate the x/y shadows.
  - A skipped state advances in 1 cycle with master_write=0.
  - Shadows are invalid after reset.
- When undefined: every beat is issued and no shadow logic exists.

Decomposition:
- Package render_pkg:
  - Register address constants: ADDR_X=1, ADDR_Y=2, ADDR_NEG=3, ADDR_TEX=4, ADDR_PLOT=6.
  - FSM state enum.
  - Packed cmd_t struct {tex[8], x[9], y[8], neg[1]}.
- Sub-module render_cmd_fifo: synchronous FIFO of cmd_t with DEPTH entries and full/empty flags.

Test Plan:
- Fill: push tex=0xFC (1_11_11_00), waitrequest=0 → beats (4,0xFC),(6,0); plots_done=1; busy falls 1 cycle after the PLOT accept.
- Sprite: push tex=0x01,x=20,y=20,neg=0 → beats (4,1),(1,20),(2,20),(6,0) on consecutive cycles starting 2 cycles after the handshake.
- Negative: push tex=0x06,x=1,y=1,neg=1 → beats (4,6),(3,1),(1,1),(2,1),(3,0),(6,0).
- Stall: hold waitrequest=1 for 50 cycles during the PLOT beat → address, data and write stable throughout; next command's TEX beat follows the release.
- Full: push 9 commands with waitrequest=1 (DEPTH=8) → cmd_ready=0 after the 8th stored; after release, all are issued in order and plots_done=9.
- Reset mid-sequence: deassert rst_n during the X beat → master_write=0, busy=0, FIFO empty asynchronously; no further beats occur after reset release. With RENDER_CMD_SKIP_EN, repeating the same sprite issues only (6,0).
